// File: rtl/quad_home_ctrl.sv
// ---------------------------------------------------------------------------
// quad_home_ctrl
//
// Purpose:
//   Homing sequencer for a quadrature-encoded motor axis. A start request
//   drives the motor in reverse until the home switch is seen. It then drives
//   forward until a minimum number of forward counts has been taken and the
//   switch has released. The position is zeroed and the axis reports homed.
//   The position counter tracks the decoder in every state. A stall watchdog
//   and a direction check send the sequencer to FAULT. Only abort or reset
//   leave FAULT.
//
// Ports:
//   clk             in   rising-edge clock for all state
//   reset           in   synchronous active-high reset
//   start           in   single-cycle request to begin (or redo) homing
//   abort           in   single-cycle request to stop and return to IDLE
//   count_enable    in   one-cycle decoder count pulse
//   count_direction in   decoder direction, 1=forward, 0=reverse
//   home_sw         in   asynchronous home switch, 1=active
//   motor_en        out  motor drive enable
//   motor_dir       out  motor direction, 1=forward, 0=reverse
//   position        out  signed axis position, wraps modulo 2^POS_W
//   homed           out  high while in READY
//   busy            out  high in SEEK, BACKOFF and ZERO
//   fault           out  high in FAULT
//   state           out  IDLE=0 SEEK=1 BACKOFF=2 ZERO=3 READY=4 FAULT=5
// ---------------------------------------------------------------------------
module quad_home_ctrl #(
  parameter int POS_W          = 16,
  parameter int STALL_CYCLES   = 1000,
  parameter int BACKOFF_COUNTS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             count_enable,
  input  logic             count_direction,
  input  logic             home_sw,
  output logic             motor_en,
  output logic             motor_dir,
  output logic [POS_W-1:0] position,
  output logic             homed,
  output logic             busy,
  output logic             fault,
  output logic [2:0]       state
);

  // Counter widths leave room for the saturation value itself.
  localparam int STALL_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES + 1) : 1;
  localparam int BACK_W  = (BACKOFF_COUNTS > 0) ? $clog2(BACKOFF_COUNTS + 1) : 1;

  localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(STALL_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_ZERO = {STALL_W{1'b0}};
  localparam logic [STALL_W-1:0] STALL_ONE  = {{(STALL_W-1){1'b0}}, 1'b1};
  localparam logic [BACK_W-1:0]  BACK_MAX   = BACK_W'(BACKOFF_COUNTS);
  localparam logic [BACK_W-1:0]  BACK_ZERO  = {BACK_W{1'b0}};
  localparam logic [BACK_W-1:0]  BACK_ONE   = {{(BACK_W-1){1'b0}}, 1'b1};
  localparam logic [POS_W-1:0]   POS_ZERO   = {POS_W{1'b0}};
  localparam logic [POS_W-1:0]   POS_ONE    = {{(POS_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEEK    = 3'd1,
    ST_BACKOFF = 3'd2,
    ST_ZERO    = 3'd3,
    ST_READY   = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               r_hs_meta;
  logic               r_hs;
  logic [STALL_W-1:0] r_stall;
  logic [BACK_W-1:0]  r_back;
  logic [POS_W-1:0]   r_position;
  logic               r_motor_en;
  logic               r_motor_dir;
  logic               r_homed;
  logic               r_busy;
  logic               r_fault;

  logic               w_driven;
  logic               w_stall_hit;
  logic               w_enter_drive;
  logic               w_enter_backoff;

  // Output flags {motor_en, motor_dir, homed, busy, fault} for a state.
  function automatic logic [4:0] decode_outputs(input state_t s);
    logic [4:0] f;
    case (s)
      ST_IDLE:    f = 5'b00000;
      ST_SEEK:    f = 5'b10010;
      ST_BACKOFF: f = 5'b11010;
      ST_ZERO:    f = 5'b00010;
      ST_READY:   f = 5'b00100;
      ST_FAULT:   f = 5'b00001;
      default:    f = 5'b00000;
    endcase
    return f;
  endfunction

  // Two-flop synchronizer for the asynchronous home switch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hs_meta <= 1'b0;
      r_hs      <= 1'b0;
    end else begin
      r_hs_meta <= home_sw;
      r_hs      <= r_hs_meta;
    end
  end

  // Qualifiers shared by the FSM and the timers.
  always_comb begin
    w_driven        = (r_state == ST_SEEK) || (r_state == ST_BACKOFF);
    // A count in the same cycle rescues a timer sitting at its limit.
    w_stall_hit     = w_driven && (r_stall == STALL_MAX) && !count_enable;
    w_enter_drive   = ((w_next_state == ST_SEEK) || (w_next_state == ST_BACKOFF)) &&
                      (w_next_state != r_state);
    w_enter_backoff = (w_next_state == ST_BACKOFF) && (r_state != ST_BACKOFF);
  end

  // Next-state logic; abort outranks every other condition.
  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_next_state = ST_SEEK;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
        ST_SEEK: begin
          // A forward count while driving reverse means miswiring.
          if (count_enable && count_direction) begin
            w_next_state = ST_FAULT;
          end else if (w_stall_hit) begin
            w_next_state = ST_FAULT;
          end else if (r_hs) begin
            w_next_state = ST_BACKOFF;
          end else begin
            w_next_state = ST_SEEK;
          end
        end
        ST_BACKOFF: begin
          if (w_stall_hit) begin
            w_next_state = ST_FAULT;
          end else if ((r_back >= BACK_MAX) && !r_hs) begin
            w_next_state = ST_ZERO;
          end else begin
            w_next_state = ST_BACKOFF;
          end
        end
        ST_ZERO: begin
          w_next_state = ST_READY;
        end
        ST_READY: begin
          if (start) begin
            w_next_state = ST_SEEK;
          end else begin
            w_next_state = ST_READY;
          end
        end
        ST_FAULT: begin
          w_next_state = ST_FAULT;
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Output flags are registered from the next state, so they always match
  // the decode of the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      {r_motor_en, r_motor_dir, r_homed, r_busy, r_fault} <= 5'b00000;
    end else begin
      {r_motor_en, r_motor_dir, r_homed, r_busy, r_fault} <= decode_outputs(w_next_state);
    end
  end

  // Stall watchdog: cycles spent driving since entry or the last count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall <= STALL_ZERO;
    end else if (w_enter_drive || count_enable) begin
      r_stall <= STALL_ZERO;
    end else if (w_driven && (r_stall != STALL_MAX)) begin
      r_stall <= r_stall + STALL_ONE;
    end else begin
      r_stall <= r_stall;
    end
  end

  // Forward counts taken since entering BACKOFF, saturating at the target.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_back <= BACK_ZERO;
    end else if (w_enter_backoff) begin
      r_back <= BACK_ZERO;
    end else if ((r_state == ST_BACKOFF) && count_enable && count_direction &&
                 (r_back != BACK_MAX)) begin
      r_back <= r_back + BACK_ONE;
    end else begin
      r_back <= r_back;
    end
  end

  // Axis position: zeroed in ZERO (that cycle's count is dropped),
  // otherwise follows the decoder with natural wrap-around.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_position <= POS_ZERO;
    end else if (r_state == ST_ZERO) begin
      r_position <= POS_ZERO;
    end else if (count_enable) begin
      if (count_direction) begin
        r_position <= r_position + POS_ONE;
      end else begin
        r_position <= r_position - POS_ONE;
      end
    end else begin
      r_position <= r_position;
    end
  end

  assign motor_en  = r_motor_en;
  assign motor_dir = r_motor_dir;
  assign homed     = r_homed;
  assign busy      = r_busy;
  assign fault     = r_fault;
  assign position  = r_position;
  assign state     = r_state;

endmodule
